rtc_pps_gen: RTL and testbench

Time-of-day event generator sitting directly downstream of the `rtc` block. It consumes the running `time_reg_sec` / `time_reg_ns` outputs and produces a one-pulse-per-second (1PPS) output of programmable width aligned to each seconds rollover. It also provides an armable time-of-day alarm that fires a single-cycle trigger when RTC time reaches a loaded target. Both outputs are for host/PHY event signalling in the PTP datapath.

---
 rtl/rtc_pps_gen.sv | 132 +++++++++++++
 tb/tb_rtc_pps_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_pps_gen.sv
// rtc_pps_gen: 1PPS pulse of programmable width aligned to each RTC seconds change,
// plus a time-of-day alarm compiled in only when RTC_PPS_ALARM_EN is defined.
module rtc_pps_gen #(
  parameter logic [15:0] PPS_WIDTH_DEFAULT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [37:0] time_reg_ns,
  input  logic [47:0] time_reg_sec,
  input  logic        pps_width_ld,
  input  logic [15:0] pps_width_in,
  output logic        pps_out,
  input  logic        alarm_ld,
  input  logic [47:0] alarm_sec_in,
  input  logic [29:0] alarm_ns_in,
  input  logic        alarm_cancel,
  output logic        alarm_armed,
  output logic        alarm_fire,
  output logic [1:0]  alarm_state_dbg
);

  // Load/cancel strobes are single-cycle level samples; there is no back-pressure.
  logic [47:0] sec_q;
  logic [29:0] ns_q;
  logic        valid_q;
  logic [15:0] width_q;
  logic [15:0] pps_cnt_q, pps_cnt_d;
  logic        pps_q, pps_d;
  logic        roll;
  logic        unused_bits;

  // valid_q masks the very first sample so reset release never looks like a rollover.
  assign roll = valid_q & (time_reg_sec != sec_q);

  always_comb begin
    pps_cnt_d = pps_cnt_q;
    pps_d     = pps_q;
    if (roll && (width_q != 16'd0)) begin
      pps_cnt_d = width_q;
      pps_d     = 1'b1;
    end else if (pps_cnt_q != 16'd0) begin
      pps_cnt_d = pps_cnt_q - 16'd1;
      pps_d     = (pps_cnt_q != 16'd1);
    end else begin
      pps_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q     <= '0;
      ns_q      <= '0;
      valid_q   <= 1'b0;
      width_q   <= PPS_WIDTH_DEFAULT;
      pps_cnt_q <= '0;
      pps_q     <= 1'b0;
    end else begin
      sec_q     <= time_reg_sec;
      ns_q      <= time_reg_ns[37:8];
      valid_q   <= 1'b1;
      pps_cnt_q <= pps_cnt_d;
      pps_q     <= pps_d;
      if (pps_width_ld) begin
        width_q <= pps_width_in;
      end
    end
  end

  assign pps_out = pps_q;

`ifdef RTC_PPS_ALARM_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } alarm_state_e;

  alarm_state_e state_q;
  logic [77:0]  target_q;
  logic         armed_q;
  logic         fire_q;
  logic         hit;

  // Compare against the live time so the fire lands one edge after the target is reached.
  assign hit = ({time_reg_sec, time_reg_ns[37:8]} >= target_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      armed_q  <= 1'b0;
      fire_q   <= 1'b0;
    end else if (alarm_ld) begin
      target_q <= {alarm_sec_in, alarm_ns_in};
      state_q  <= ST_ARMED;
      armed_q  <= 1'b1;
      fire_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (alarm_cancel) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            fire_q  <= 1'b0;
          end else if (hit) begin
            state_q <= ST_FIRED;
            armed_q <= 1'b0;
            fire_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          armed_q <= 1'b0;
          fire_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_armed     = armed_q;
  assign alarm_fire      = fire_q;
  assign alarm_state_dbg = state_q;
  assign unused_bits     = ^{ns_q, time_reg_ns[7:0]};
`else
  assign alarm_armed     = 1'b0;
  assign alarm_fire      = 1'b0;
  assign alarm_state_dbg = 2'd0;
  assign unused_bits     = ^{ns_q, time_reg_ns[7:0], alarm_ld, alarm_sec_in,
                             alarm_ns_in, alarm_cancel};
`endif

endmodule

// File: tb/tb_rtc_pps_gen.sv
// Bench for rtc_pps_gen: time-stamp based reference model checked every cycle,
// plus directed scenarios with hand-computed pulse/fire positions.
module tb_rtc_pps_gen;

  localparam int unsigned NS_PER_SEC = 32'd1000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] ns_v = '0;
  logic [7:0]  frac_v = '0;
  logic [37:0] time_reg_ns;
  logic [47:0] time_reg_sec = 48'd10;
  logic        pps_width_ld = 1'b0;
  logic [15:0] pps_width_in = '0;
  logic        pps_out;
  logic        alarm_ld = 1'b0;
  logic [47:0] alarm_sec_in = '0;
  logic [29:0] alarm_ns_in = '0;
  logic        alarm_cancel = 1'b0;
  logic        alarm_armed;
  logic        alarm_fire;
  logic [1:0]  dbg_state_unused;

  assign time_reg_ns = {ns_v, frac_v};

  rtc_pps_gen #(.PPS_WIDTH_DEFAULT(16'd1000)) dut (
    .clk            (clk),
    .rst            (rst),
    .time_reg_ns    (time_reg_ns),
    .time_reg_sec   (time_reg_sec),
    .pps_width_ld   (pps_width_ld),
    .pps_width_in   (pps_width_in),
    .pps_out        (pps_out),
    .alarm_ld       (alarm_ld),
    .alarm_sec_in   (alarm_sec_in),
    .alarm_ns_in    (alarm_ns_in),
    .alarm_cancel   (alarm_cancel),
    .alarm_armed    (alarm_armed),
    .alarm_fire     (alarm_fire),
    .alarm_state_dbg(dbg_state_unused)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // PPS expressed as "last edge index the pulse covers"; alarm as armed flag + target time.
  int          m_edge = 0;
  int          m_pps_end = -1;
  bit          m_have_prev = 1'b0;
  logic [47:0] m_prev_sec = '0;
  int          m_width = 1000;
  bit          m_armed = 1'b0;
  bit          m_fire = 1'b0;
  logic [47:0] m_tsec = '0;
  logic [29:0] m_tns = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_have_prev = 1'b0;
      m_width     = 1000;
      m_pps_end   = -1;
      m_armed     = 1'b0;
      m_fire      = 1'b0;
    end else begin
      m_edge++;
      if (m_have_prev && (time_reg_sec != m_prev_sec) && (m_width != 0))
        m_pps_end = m_edge + m_width - 1;
      if (pps_width_ld) m_width = int'(pps_width_in);
      m_prev_sec  = time_reg_sec;
      m_have_prev = 1'b1;
`ifdef RTC_PPS_ALARM_EN
      m_fire = 1'b0;
      if (alarm_ld) begin
        m_armed = 1'b1;
        m_tsec  = alarm_sec_in;
        m_tns   = alarm_ns_in;
      end else if (m_armed) begin
        if (alarm_cancel) begin
          m_armed = 1'b0;
        end else if ((time_reg_sec > m_tsec) ||
                     ((time_reg_sec == m_tsec) && (ns_v >= m_tns))) begin
          m_armed = 1'b0;
          m_fire  = 1'b1;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    chk("pps_out", int'(pps_out), int'(m_pps_end >= m_edge));
    chk("alarm_armed", int'(alarm_armed), int'(m_armed));
    chk("alarm_fire", int'(alarm_fire), int'(m_fire));
  end

  // ---------------- window statistics (relative to mark) ----------------
  int cyc = 0;
  int mark_cyc = 0;
  int rel;
  int s_pps = 0, s_first = -1, s_last = -1;
  int s_fire = 0, s_fire_first = -1, s_armed = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    rel = cyc - mark_cyc;
    if (pps_out) begin
      s_pps++;
      if (s_first < 0) s_first = rel;
      s_last = rel;
    end
    if (alarm_fire) begin
      s_fire++;
      if (s_fire_first < 0) s_fire_first = rel;
    end
    if (alarm_armed) s_armed++;
  end

  // ---------------- driver tasks ----------------
  task automatic mark();
    mark_cyc     = cyc;
    s_pps        = 0;
    s_first      = -1;
    s_last       = -1;
    s_fire       = 0;
    s_fire_first = -1;
    s_armed      = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      frac_v = 8'($urandom_range(0, 255));
    end
  endtask

  // RTC-like advance: 8 ns per clock, wrapping ns into seconds.
  task automatic step_ns(input int n);
    int unsigned t;
    repeat (n) begin
      tick(1);
      t = 32'(ns_v) + 32'd8;
      if (t >= NS_PER_SEC) begin
        t = t - NS_PER_SEC;
        time_reg_sec = time_reg_sec + 48'd1;
      end
      ns_v = 30'(t);
    end
  endtask

  task automatic load_width(input logic [15:0] w);
    pps_width_ld = 1'b1;
    pps_width_in = w;
    tick(1);
    pps_width_ld = 1'b0;
  endtask

  task automatic arm(input logic [47:0] s, input logic [29:0] ns);
    alarm_sec_in = s;
    alarm_ns_in  = ns;
    alarm_ld     = 1'b1;
    tick(1);
    alarm_ld     = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick(3);
    chk("reset_pps", int'(pps_out), 0);
    chk("reset_armed", int'(alarm_armed), 0);
    chk("reset_fire", int'(alarm_fire), 0);

    rst = 1'b1;
    mark();
    tick(8);
    chk("no_pps_const_sec", s_pps, 0);

    time_reg_sec = 48'd11;
    mark();
    tick(1010);
    chk("pps_default_count", s_pps, 1000);
    chk("pps_default_first", s_first, 1);
    chk("pps_default_last", s_last, 1000);

    load_width(16'd3);
    time_reg_sec = 48'd12;
    mark();
    tick(10);
    chk("pps_w3_count", s_pps, 3);
    chk("pps_w3_last", s_last, 3);

    load_width(16'd0);
    time_reg_sec = 48'd13;
    mark();
    tick(10);
    chk("pps_w0_count", s_pps, 0);

    load_width(16'd10);
    time_reg_sec = 48'd21;
    mark();
    tick(5);
    time_reg_sec = 48'd22;
    tick(20);
    chk("pps_restart_count", s_pps, 15);
    chk("pps_restart_first", s_first, 1);
    chk("pps_restart_last", s_last, 15);

    time_reg_sec = 48'd5;
    mark();
    tick(15);
    chk("pps_backward_count", s_pps, 10);
    chk("pps_backward_last", s_last, 10);

    // Alarm reached by a running RTC: ns hits 999999996 after 12 steps of 8 ns.
    time_reg_sec = 48'd10;
    ns_v = 30'd999999900;
    tick(12);
    arm(48'd10, 30'd999999996);
    mark();
    step_ns(20);
`ifdef RTC_PPS_ALARM_EN
    chk("alarm_run_fire_count", s_fire, 1);
    chk("alarm_run_fire_rel", s_fire_first, 13);
    chk("alarm_run_armed_cycles", s_armed, 13);
`else
    chk("alarm_run_fire_count", s_fire, 0);
    chk("alarm_run_armed_cycles", s_armed, 0);
`endif
    chk("alarm_run_armed_after", int'(alarm_armed), 0);

    arm(48'd5, 30'd0);
    mark();
    tick(5);
`ifdef RTC_PPS_ALARM_EN
    chk("alarm_past_fire_count", s_fire, 1);
    chk("alarm_past_fire_rel", s_fire_first, 1);
    chk("alarm_past_armed_cycles", s_armed, 1);
`else
    chk("alarm_past_fire_count", s_fire, 0);
`endif

    arm(48'd100, 30'd0);
    mark();
    tick(2);
    alarm_cancel = 1'b1;
    tick(1);
    alarm_cancel = 1'b0;
    tick(4);
    chk("alarm_cancel_fire_count", s_fire, 0);
`ifdef RTC_PPS_ALARM_EN
    chk("alarm_cancel_armed_cycles", s_armed, 3);
`else
    chk("alarm_cancel_armed_cycles", s_armed, 0);
`endif
    chk("alarm_cancel_armed_after", int'(alarm_armed), 0);

    arm(48'd100, 30'd0);
    tick(1);
    time_reg_sec = 48'd150;
    alarm_sec_in = 48'd200;
    alarm_ns_in  = 30'd0;
    alarm_ld     = 1'b1;
    mark();
    tick(1);
    alarm_ld = 1'b0;
    tick(4);
    chk("alarm_reload_fire_count", s_fire, 0);
`ifdef RTC_PPS_ALARM_EN
    chk("alarm_reload_armed_cycles", s_armed, 5);
    chk("alarm_reload_armed_after", int'(alarm_armed), 1);
`else
    chk("alarm_reload_armed_cycles", s_armed, 0);
`endif

    // Reset in the middle of a pulse and while armed.
    time_reg_sec = 48'd151;
    tick(3);
    chk("pre_reset_pps_high", int'(pps_out), 1);
    rst = 1'b0;
    #1;
    chk("async_reset_pps", int'(pps_out), 0);
    chk("async_reset_armed", int'(alarm_armed), 0);
    chk("async_reset_fire", int'(alarm_fire), 0);
    tick(2);
    rst = 1'b1;
    time_reg_sec = 48'd300;
    mark();
    tick(12);
    chk("post_reset_no_pps", s_pps, 0);

    time_reg_sec = 48'd301;
    mark();
    tick(1005);
    chk("post_reset_width_default", s_pps, 1000);
    chk("post_reset_first", s_first, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
